decoder_stream: RTL and testbench
=================================

// Module: decoder_stream
// PURPOSE
//  Parametrised streaming successor to the io_in code decoder. It accepts an IN_W-bit code
//  with a per-transfer mode and returns an OUT_W-bit decoded word: one-hot, thermometer or
//  active-low one-hot. Transfers use valid/ready on both sides through a 2-entry output buffer,
//  giving full throughput. Out-of-range codes are flagged and counted for the formal cover harness.
// PARAMETERS
//  IN_W       3   code width in bits; 1..6
//  OUT_W      8   decoded width; IN_W+1 <= OUT_W <= 2**IN_W
//  ERR_CNT_W  8   width of saturating error counter
// PORTS
//  clock      in   1          single clock, all state on rising edge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          code/mode present
//  in_ready   out  1          buffer can accept (registered, = count<2)
//  in_code    in   IN_W       binary code
//  in_mode    in   2          00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved
//  out_valid  out  1          head entry valid (= count!=0)
//  out_ready  in   1          consumer accepts head
//  out_data   out  OUT_W      decoded word of head entry
//  out_err    out  1          head entry was out-of-range or reserved mode
//  err_count  out  ERR_CNT_W  saturating count of accepted erroneous transfers
// BEHAVIOUR
//  - Reset (sync): count=0, in_ready=1, out_valid=0, out_data=0, out_err=0, err_count=0.
//    Reset mid-operation discards buffered entries; no transfer completes in the reset cycle.
//  - Accept when in_valid&in_ready; pop when out_valid&out_ready. Both in one cycle at count=1:
//    count stays 1, new entry becomes head next cycle. At count=2 in_ready=0, so no push.
//  - Latency: code accepted in cycle t appears on out_data in cycle t+1 if buffer was empty.
//  - Decode (combinational, before buffer write), c=in_code:
//    one-hot:    bit c set, others 0
//    thermo:     bits [c:0] set; c=0 -> 1
//    act-low:    ~one-hot
//    reserved:   data = one-hot of c, err=1
//  - Out-of-range: c >= OUT_W gives data = 0 (all ones in act-low mode), err=1.
//  - err_count increments by 1 on each accepted entry with err=1 and saturates at all ones.
//    It increments on accept, not on pop.
//  - Buffer is FIFO order. Head out_data/out_err are stable while out_valid&!out_ready.
//  - out_data/out_err are don't-care when out_valid=0; implementation drives head register.
//  - No combinational path from out_ready to in_ready.
// STRUCTURE
//  - decoder_pkg: mode localparams MODE_ONEHOT=2'b00, MODE_THERMO=2'b01, MODE_ACTLOW=2'b10,
//    MODE_RSVD=2'b11; function decode_word(code, mode) -> {err, data}.
//  - Sub-module decoder_fifo2:
//    - 2-entry register FIFO, width OUT_W+1, with count, wr/rd pointers, full/empty.
//    - decoder_stream instantiates it and adds decode and err_count logic.
//  - Elaboration check: error if OUT_W > 2**IN_W or OUT_W < IN_W+1.
// TESTING (IN_W=3, OUT_W=6, ERR_CNT_W=2 unless noted)
//  1. Streaming: code=5, mode 00, out_ready=1 -> next cycle out_data=6'b100000, err=0.
//     Back-to-back codes 0..5 -> one word per cycle.
//  2. Backpressure: out_ready=0; push codes 2 and 3 in mode 01 -> after 2 accepts in_ready=0.
//     Head 6'b000111 held; release -> 6'b000111 then 6'b001111.
//  3. Range and reserved mode:
//     - code=7, mode 10 -> out_data=6'b111111, err=1.
//     - code=1, mode 11 -> 6'b000010, err=1.
//     - 4 errors total -> err_count saturates at 2'b11.
//  4. Simultaneous push/pop at count=1 -> count stays 1, order preserved, no drop or duplicate.
//  5. Reset mid-stream: count=2, reset high 1 cycle -> out_valid=0, in_ready=1, err_count=0.
//     Next accept appears 1 cycle later.
//  6. Formal cover: io_in-style 7-bit stimulus 7'b1110011 maps to in_valid=1, mode=11, code=3.
//     -> out_data=6'b001000, err=1.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared mode encodings and the code-to-word decode function for the streaming decoder.
package decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_ACTLOW = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int unsigned MAX_IN_W  = 6;
  localparam int unsigned MAX_OUT_W = 64;

  // Returns {err, data}; data is built at maximum width and narrowed by the caller.
  // Out-of-range codes yield an empty word, which inverts to all ones in active-low mode.
  function automatic logic [MAX_OUT_W:0] decode_word(
    input logic [MAX_IN_W-1:0] code,
    input logic [1:0]          mode,
    input int unsigned         out_w
  );
    logic [MAX_OUT_W-1:0] data;
    logic                 err;
    int unsigned          c;
    c    = 32'(code);
    data = '0;
    err  = (c >= out_w) || (mode == MODE_RSVD);
    if (c < out_w) begin
      for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
        if (mode == MODE_THERMO) data[i] = (i <= c);
        else                     data[i] = (i == c);
      end
    end
    if (mode == MODE_ACTLOW) data = ~data;
    return {err, data};
  endfunction

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry register FIFO with registered ready/valid flags and a registered head word.
module decoder_fifo2 #(
  parameter int unsigned W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic         wr_ptr_d, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         full_d, empty_d;
  logic         push, pop;
  logic [W-1:0] head_d;

  // Next-state: pointers, occupancy and the word that will sit at the head.
  always_comb begin
    push     = wr_valid & wr_ready;
    pop      = rd_valid & rd_ready;
    count_d  = count_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    full_d   = (count_d == 2'd2);
    empty_d  = (count_d == 2'd0);
    // A word written into the slot that becomes the head bypasses the storage read.
    head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      wr_ready <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ready <= !full_d;
      rd_valid <= !empty_d;
      rd_data  <= head_d;
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Streaming code decoder: decodes each accepted code/mode into a word, buffers it in a
// two-entry FIFO and keeps a saturating count of erroneous transfers.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W      = 3,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_bad_in_w
    $error("decoder_stream: IN_W must be within 1..6");
  end
  if (OUT_W > (1 << IN_W) || OUT_W < IN_W + 1) begin : g_bad_out_w
    $error("decoder_stream: OUT_W must satisfy IN_W+1 <= OUT_W <= 2**IN_W");
  end

  localparam int unsigned ENTRY_W = OUT_W + 1;

  logic [MAX_OUT_W:0]     dec_word;
  logic [ENTRY_W-1:0]     wr_entry;
  logic [ENTRY_W-1:0]     rd_entry;
  logic                   accept;
  logic [ERR_CNT_W-1:0]   err_count_d;

  // Decode ahead of the buffer write; entry layout is {err, data}.
  always_comb begin
    dec_word = decode_word(MAX_IN_W'(in_code), in_mode, OUT_W);
    wr_entry = {dec_word[MAX_OUT_W], OUT_W'(dec_word[MAX_OUT_W-1:0])};
  end

  decoder_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_entry)
  );

  always_comb begin
    out_err  = rd_entry[OUT_W];
    out_data = rd_entry[OUT_W-1:0];
  end

  // Error count advances on accept, holding at all ones once saturated.
  always_comb begin
    accept      = in_valid & in_ready;
    err_count_d = err_count;
    if (accept && wr_entry[OUT_W] && (err_count != {ERR_CNT_W{1'b1}}))
      err_count_d = err_count + ERR_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) err_count <= '0;
    else       err_count <= err_count_d;
  end

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream (IN_W=3, OUT_W=6, ERR_CNT_W=2): queue model plus directed literals.
module tb_decoder_stream;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_data;
  logic       out_err;
  logic [1:0] err_count;

  int checks = 0;
  int failures = 0;

  decoder_stream #(.IN_W(3), .OUT_W(6), .ERR_CNT_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] model_decode(input int c, input int m);
    logic [5:0] d;
    logic       e;
    e = (m == 3) || (c >= 6);
    if (c >= 6)      d = 6'd0;
    else if (m == 1) d = 6'((1 << (c + 1)) - 1);
    else             d = 6'(1 << c);
    if (m == 2) d = ~d;
    return {e, d};
  endfunction

  logic [6:0] mq[$];
  int         m_errs = 0;

  // Model advances on each rising edge from its own occupancy.
  always @(posedge clock) begin
    bit acc, pp;
    if (reset) begin
      mq.delete();
      m_errs = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      pp  = (mq.size() != 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        logic [6:0] w;
        w = model_decode(int'(in_code), int'(in_mode));
        mq.push_back(w);
        if (w[6] && m_errs < 3) m_errs++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every non-reset cycle on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("m_err_count", 32'(err_count), 32'(m_errs));
      if (mq.size() != 0) begin
        chk("m_out_data", 32'(out_data), 32'(mq[0][5:0]));
        chk("m_out_err", 32'(out_err), 32'(mq[0][6]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input int c, input int m, input bit r);
    in_valid  = v;
    in_code   = 3'(c);
    in_mode   = 2'(m);
    out_ready = r;
  endtask

  task automatic drain();
    drive(0, 0, 0, 1);
    repeat (3) step();
  endtask

  initial begin
    logic [6:0] stim;
    // reset state
    reset = 1'b1;
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    // 1. streaming
    drive(1, 5, 0, 1);
    step();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_data", 32'(out_data), 32'b100000);
    chk("s1_err", 32'(out_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1, i, 0, 1);
      step();
      chk("s1_b2b", 32'(out_data), 32'(1 << i));
    end
    drain();

    // 2. backpressure
    drive(1, 2, 1, 0);
    step();
    drive(1, 3, 1, 0);
    step();
    chk("s2_full", 32'(in_ready), 32'd0);
    drive(0, 0, 0, 0);
    repeat (2) step();
    chk("s2_hold", 32'(out_data), 32'b000111);
    out_ready = 1'b1;
    chk("s2_head0", 32'(out_data), 32'b000111);
    step();
    chk("s2_head1", 32'(out_data), 32'b001111);
    step();
    chk("s2_empty", 32'(out_valid), 32'd0);

    // 3. range and reserved mode
    drive(1, 7, 2, 1);
    step();
    chk("s3_oor_data", 32'(out_data), 32'b111111);
    chk("s3_oor_err", 32'(out_err), 32'd1);
    drive(1, 1, 3, 1);
    step();
    chk("s3_rsvd_data", 32'(out_data), 32'b000010);
    chk("s3_rsvd_err", 32'(out_err), 32'd1);
    drive(1, 6, 0, 1);
    step();
    chk("s3_cnt3", 32'(err_count), 32'd3);
    drive(1, 7, 1, 1);
    step();
    chk("s3_sat", 32'(err_count), 32'b11);
    chk("s3_thermo_oor", 32'(out_data), 32'd0);
    drain();

    // 4. simultaneous push/pop at count=1
    drive(1, 1, 0, 0);
    step();
    drive(1, 4, 1, 1);
    step();
    chk("s4_head", 32'(out_data), 32'b011111);
    chk("s4_ready", 32'(in_ready), 32'd1);
    drive(1, 0, 1, 1);
    step();
    chk("s4_next", 32'(out_data), 32'b000001);
    for (int i = 0; i < 24; i++) begin
      drive(((i % 3) != 2), i % 8, (i / 2) % 4, ((i % 4) != 1));
      step();
    end
    drain();

    // 5. reset mid-stream
    drive(1, 2, 3, 0);
    step();
    drive(1, 3, 0, 0);
    step();
    chk("s5_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    drive(1, 5, 0, 1);
    step();
    reset = 1'b0;
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_ready", 32'(in_ready), 32'd1);
    chk("s5_errcnt", 32'(err_count), 32'd0);
    drive(1, 4, 0, 1);
    step();
    chk("s5_after", 32'(out_data), 32'b010000);
    chk("s5_after_v", 32'(out_valid), 32'd1);
    drain();

    // 6. io_in-style stimulus: {valid, mode[1:0], spare, code[2:0]}
    stim = 7'b1110011;
    drive(stim[6], int'(stim[2:0]), int'(stim[5:4]), 1);
    step();
    chk("s6_data", 32'(out_data), 32'b001000);
    chk("s6_err", 32'(out_err), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
